// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave:
//   - spi_state_e : FSM state encoding of spi_slave
//   - CMD_*       : two-bit command codes carried in rx_data[9:8]
//   - CMD_W       : width of the command field
//   - FRAME_W     : rx frame width for the default 8-bit data width
// ---------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHK_CMD   = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_ADD  = 3'd3,
      ST_READ_DATA = 3'd4
   } spi_state_e;

   localparam int unsigned CMD_W   = 2;
   localparam int unsigned FRAME_W = 10;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage : spi_pkg

// File: rtl/spi_tx_serializer.sv
// ---------------------------------------------------------------------------
// spi_tx_serializer
// Latches read data from the RAM once per read and shifts it out on MISO,
// MSB first, one bit per clock, starting the cycle after the latch.
// Optional build macro: SPI_SLAVE_FRAME_ERR_EN (adds pending_o).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr_i          : drop any read in progress, MISO back to 0
//   arm_i          : read frame complete, accept tx_valid_i
//   tx_valid_i     : tx_data_i valid
//   tx_data_i      : byte to serialise
//   miso_o         : serial output (0 when idle)
//   done_o         : high in the cycle after bit 0 was driven
//   pending_o      : read not yet finished (macro builds only)
// ---------------------------------------------------------------------------
module spi_tx_serializer #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  arm_i,
   input  logic                  tx_valid_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   output logic                  miso_o,
   output logic                  done_o
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,output logic                 pending_o
`endif
);

   localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] latch_q, latch_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  active_q, active_d;
   logic                  last_q, last_d;
   logic                  finished_q, finished_d;
   logic                  miso_q, miso_d;

   // Next-state logic: latch once per armed read, then walk the bit index down.
   always_comb begin
      latch_d    = latch_q;
      cnt_d      = cnt_q;
      active_d   = active_q;
      last_d     = last_q;
      finished_d = finished_q;
      miso_d     = miso_q;
      if (clr_i) begin
         active_d   = 1'b0;
         last_d     = 1'b0;
         finished_d = 1'b0;
         cnt_d      = {CW{1'b0}};
         miso_d     = 1'b0;
      end else if (active_q) begin
         if (last_q) begin
            // bit 0 has had its full cycle on the wire
            miso_d     = 1'b0;
            active_d   = 1'b0;
            last_d     = 1'b0;
            finished_d = 1'b1;
         end else begin
            miso_d = latch_q[cnt_q];
            if (cnt_q == {CW{1'b0}}) begin
               last_d = 1'b1;
            end else begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
      end else if (arm_i && !finished_q && tx_valid_i) begin
         latch_d  = tx_data_i;
         active_d = 1'b1;
         cnt_d    = CW'(DATA_WIDTH - 1);
         miso_d   = 1'b0;
      end else begin
         miso_d = 1'b0;
      end
   end

   // Serializer state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_q    <= {DATA_WIDTH{1'b0}};
         cnt_q      <= {CW{1'b0}};
         active_q   <= 1'b0;
         last_q     <= 1'b0;
         finished_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         latch_q    <= latch_d;
         cnt_q      <= cnt_d;
         active_q   <= active_d;
         last_q     <= last_d;
         finished_q <= finished_d;
         miso_q     <= miso_d;
      end
   end

   assign miso_o = miso_q;
   assign done_o = active_q & last_q;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   assign pending_o = ~finished_q & ~last_q;
`endif

endmodule : spi_tx_serializer

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
// SPI slave front end for a small RAM. A transaction is a command bit
// followed by a DATA_WIDTH+2 bit frame, MSB first, sampled on every rising
// clk edge while SS_n is low. Reads are two transactions: address, then data.
// Optional build macro: SPI_SLAVE_FRAME_ERR_EN (adds frame_err output).
// Ports:
//   clk       : system clock (one SPI bit per clock)
//   rst_n     : asynchronous active-low reset
//   SS_n      : slave select, active low
//   MOSI      : serial data in
//   MISO      : serial data out, 0 when not serialising
//   rx_data   : received frame, [9:8] command, [7:0] address/data
//   rx_valid  : one-cycle strobe for rx_data
//   tx_data   : read data from RAM
//   tx_valid  : tx_data valid
//   frame_err : one-cycle pulse on aborted frame/read (macro builds only)
// ---------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  SS_n,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic [DATA_WIDTH+1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,output logic                 frame_err
`endif
);

   localparam int unsigned FW  = DATA_WIDTH + CMD_W;
   localparam int unsigned BCW = $clog2(FW);

   spi_state_e       state_q, state_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [FW-2:0]    shift_q, shift_d;
   logic [FW-1:0]    rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             rd_addr_flag_q, rd_addr_flag_d;
   logic             ra_done_s;
   logic             ser_done_s;
   logic             ser_clr_s;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic             ser_pending_s;
   logic             frame_err_q, frame_err_d;
`endif

   // Main FSM: command decode, frame shifting, abort on SS_n high.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      frame_done_d = frame_done_q;
      ra_done_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!SS_n) begin
               state_d = ST_CHK_CMD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHK_CMD: begin
            bit_cnt_d    = {BCW{1'b0}};
            frame_done_d = 1'b0;
            if (SS_n) begin
               state_d = ST_IDLE;
            end else if (!MOSI) begin
               state_d = ST_WRITE;
            end else if (rd_addr_flag_q) begin
               state_d = ST_READ_DATA;
            end else begin
               state_d = ST_READ_ADD;
            end
         end
         ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            if (SS_n) begin
               // partial frames are dropped without a strobe
               state_d      = ST_IDLE;
               bit_cnt_d    = {BCW{1'b0}};
               frame_done_d = 1'b0;
            end else if (!frame_done_q) begin
               shift_d = {shift_q[FW-3:0], MOSI};
               if (bit_cnt_q == BCW'(FW - 1)) begin
                  rx_data_d    = {shift_q, MOSI};
                  rx_valid_d   = 1'b1;
                  bit_cnt_d    = {BCW{1'b0}};
                  frame_done_d = 1'b1;
                  ra_done_s    = (state_q == ST_READ_ADD);
               end else begin
                  bit_cnt_d = bit_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
               end
            end else begin
               // frame complete: park here and ignore MOSI until deselect
               state_d = state_q;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            bit_cnt_d    = {BCW{1'b0}};
            frame_done_d = 1'b0;
         end
      endcase
   end

   // Read-address flag: set by a finished address read, cleared once bit 0 of the data is out.
   always_comb begin
      rd_addr_flag_d = rd_addr_flag_q;
      if (ra_done_s) begin
         rd_addr_flag_d = 1'b1;
      end else if (ser_done_s) begin
         rd_addr_flag_d = 1'b0;
      end else begin
         rd_addr_flag_d = rd_addr_flag_q;
      end
   end

`ifdef SPI_SLAVE_FRAME_ERR_EN
   // Abort classification: mid-frame bits or an unfinished read reply.
   always_comb begin
      frame_err_d = 1'b0;
      if (SS_n && (state_q == ST_WRITE || state_q == ST_READ_ADD || state_q == ST_READ_DATA)) begin
         if (!frame_done_q) begin
            frame_err_d = (bit_cnt_q != {BCW{1'b0}});
         end else if (state_q == ST_READ_DATA) begin
            frame_err_d = ser_pending_s;
         end else begin
            frame_err_d = 1'b0;
         end
      end else begin
         frame_err_d = 1'b0;
      end
   end

   // Abort pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;
`endif

   // FSM and receive-path registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= {BCW{1'b0}};
         shift_q        <= {(FW-1){1'b0}};
         rx_data_q      <= {FW{1'b0}};
         rx_valid_q     <= 1'b0;
         frame_done_q   <= 1'b0;
         rd_addr_flag_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         frame_done_q   <= frame_done_d;
         rd_addr_flag_q <= rd_addr_flag_d;
      end
   end

   // Leaving READ_DATA or deselecting drops any read reply in progress.
   assign ser_clr_s = SS_n | (state_q != ST_READ_DATA);

   spi_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tx_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (ser_clr_s),
      .arm_i      (frame_done_q),
      .tx_valid_i (tx_valid),
      .tx_data_i  (tx_data),
      .miso_o     (MISO),
      .done_o     (ser_done_s)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ,.pending_o (ser_pending_s)
`endif
   );

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
// Self-checking bench for spi_slave. Inputs change and outputs are observed
// on the falling clock edge. The expected rx frame and read-address flag are
// tracked from the transaction-level rules (command bit + frame, read reply).
// ---------------------------------------------------------------------------
module tb_spi_slave;
   import spi_pkg::*;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          SS_n;
   logic          MOSI;
   logic          MISO;
   logic [DW+1:0] rx_data;
   logic          rx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic          frame_err;
`endif

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW+1:0] exp_rx_data;
   bit            exp_flag;

   always #5 clk = ~clk;

   spi_slave #(.DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ,.frame_err (frame_err)
`endif
   );

   // One command bit plus nbits frame bits; nbits < 10 leaves the frame partial.
   task automatic drv_frame(input bit cmd, input logic [9:0] frm, input int nbits, input bit noisy_tx);
      bit to_ra;
      to_ra = cmd & ~exp_flag;
      SS_n = 1'b0; MOSI = cmd;
      @(negedge clk);
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL cmd0_rx_valid: got %0b want 0", rx_valid); end
      MOSI = cmd;
      @(negedge clk);
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL cmd1_rx_valid: got %0b want 0", rx_valid); end
      for (int i = 0; i < nbits; i++) begin
         MOSI = frm[9-i];
         if (noisy_tx) begin tx_valid = 1'($urandom_range(0, 1)); tx_data = 8'($urandom); end
         @(negedge clk);
         if (i == 9) begin
            exp_rx_data = frm;
            if (to_ra) exp_flag = 1'b1;
         end
         n_vec++; if (rx_valid !== 1'(i == 9)) begin n_err++; $display("FAIL frame_rx_valid bit%0d: got %0b want %0b", i, rx_valid, (i == 9)); end
         n_vec++; if (rx_data !== exp_rx_data) begin n_err++; $display("FAIL frame_rx_data bit%0d: got %0h want %0h", i, rx_data, exp_rx_data); end
         n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL frame_miso bit%0d: got %0b want 0", i, MISO); end
      end
      tx_valid = 1'b0;
      MOSI = 1'($urandom_range(0, 1));
   endtask

   // Sit in a non-read state with noise on MOSI/tx_valid; nothing may happen.
   task automatic drv_hold(input int n);
      for (int i = 0; i < n; i++) begin
         MOSI = 1'($urandom_range(0, 1));
         tx_valid = 1'($urandom_range(0, 1)); tx_data = 8'($urandom);
         @(negedge clk);
         n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL hold_rx_valid: got %0b want 0", rx_valid); end
         n_vec++; if (rx_data !== exp_rx_data) begin n_err++; $display("FAIL hold_rx_data: got %0h want %0h", rx_data, exp_rx_data); end
         n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL hold_miso: got %0b want 0", MISO); end
      end
      tx_valid = 1'b0;
   endtask

   // Read reply: tx_valid after 'delay' idle cycles, then observe nm MISO bits.
   task automatic drv_read(input logic [7:0] data, input int delay, input int nm);
      for (int d = 0; d < delay; d++) begin
         tx_valid = 1'b0;
         @(negedge clk);
         n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_wait_miso: got %0b want 0", MISO); end
      end
      tx_valid = 1'b1; tx_data = data;
      @(negedge clk);
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_latch_miso: got %0b want 0", MISO); end
      for (int k = 0; k < nm; k++) begin
         tx_valid = 1'($urandom_range(0, 1)); tx_data = 8'($urandom);
         @(negedge clk);
         n_vec++; if (MISO !== data[7-k]) begin n_err++; $display("FAIL rd_miso bit%0d: got %0b want %0b", 7-k, MISO, data[7-k]); end
         n_vec++; if (dut.rd_addr_flag_q !== 1'b1) begin n_err++; $display("FAIL rd_flag_during: got %0b want 1", dut.rd_addr_flag_q); end
      end
      if (nm == 8) begin
         exp_flag = 1'b0;
         for (int j = 0; j < 3; j++) begin
            tx_valid = 1'b1; tx_data = 8'($urandom);
            @(negedge clk);
            n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rd_after_miso: got %0b want 0", MISO); end
            n_vec++; if (dut.rd_addr_flag_q !== exp_flag) begin n_err++; $display("FAIL rd_flag_after: got %0b want %0b", dut.rd_addr_flag_q, exp_flag); end
         end
      end
      tx_valid = 1'b0;
   endtask

   // Deselect; expect return to idle with MISO/rx_valid low.
   task automatic drv_end(input bit exp_ferr);
      SS_n = 1'b1; MOSI = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL end_rx_valid: got %0b want 0", rx_valid); end
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL end_miso: got %0b want 0", MISO); end
      n_vec++; if (rx_data !== exp_rx_data) begin n_err++; $display("FAIL end_rx_data: got %0h want %0h", rx_data, exp_rx_data); end
      n_vec++; if (dut.rd_addr_flag_q !== exp_flag) begin n_err++; $display("FAIL end_flag: got %0b want %0b", dut.rd_addr_flag_q, exp_flag); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      n_vec++; if (frame_err !== exp_ferr) begin n_err++; $display("FAIL frame_err_pulse: got %0b want %0b", frame_err, exp_ferr); end
      @(negedge clk);
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL frame_err_clear: got %0b want 0", frame_err); end
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      exp_rx_data = 10'h000; exp_flag = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rst_miso: got %0b want 0", MISO); end
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %0b want 0", rx_valid); end
      n_vec++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL rst_rx_data: got %0h want 0", rx_data); end
      n_vec++; if (dut.rd_addr_flag_q !== 1'b0) begin n_err++; $display("FAIL rst_flag: got %0b want 0", dut.rd_addr_flag_q); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      drv_frame(1'b0, 10'h0A5, 10, 1'b0);
      drv_hold(2);
      drv_end(1'b0);
      drv_frame(1'b0, 10'h13C, 10, 1'b1);
      drv_hold(3);
      drv_end(1'b0);
      n_vec++; if (dut.rd_addr_flag_q !== 1'b0) begin n_err++; $display("FAIL wr_flag: got %0b want 0", dut.rd_addr_flag_q); end
   endtask

   task automatic test_read();
      drv_frame(1'b1, 10'h207, 10, 1'b1);
      drv_hold(2);
      drv_end(1'b0);
      n_vec++; if (dut.rd_addr_flag_q !== 1'b1) begin n_err++; $display("FAIL rd_addr_flag_set: got %0b want 1", dut.rd_addr_flag_q); end
      drv_frame(1'b1, 10'h300, 10, 1'b1);
      drv_read(8'hC3, 2, 8);
      drv_end(1'b0);
   endtask

   task automatic test_abort();
      drv_frame(1'b0, 10'h155, 5, 1'b0);
      drv_end(1'b1);
      n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL abort_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
      // read with flag set, cut after four MISO bits
      drv_frame(1'b1, 10'h2AA, 10, 1'b0);
      drv_end(1'b0);
      drv_frame(1'b1, 10'h3AA, 10, 1'b0);
      drv_read(8'h5A, 1, 4);
      drv_end(1'b1);
      n_vec++; if (dut.rd_addr_flag_q !== 1'b1) begin n_err++; $display("FAIL abort_flag_kept: got %0b want 1", dut.rd_addr_flag_q); end
      // next read command must go straight to data
      drv_frame(1'b1, 10'h3F0, 10, 1'b0);
      drv_read(8'h96, 0, 8);
      drv_end(1'b0);
      // address read cut short leaves the flag clear
      drv_frame(1'b1, 10'h2F0, 7, 1'b0);
      drv_end(1'b1);
      n_vec++; if (dut.rd_addr_flag_q !== 1'b0) begin n_err++; $display("FAIL ra_abort_flag: got %0b want 0", dut.rd_addr_flag_q); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 60; t++) begin
         bit cmd, rd_data_path;
         logic [9:0] frm;
         int mode, nm;
         cmd = 1'($urandom_range(0, 1));
         frm = 10'($urandom);
         mode = $urandom_range(0, 3);
         rd_data_path = cmd & exp_flag;
         if (mode == 0) begin
            drv_frame(cmd, frm, $urandom_range(1, 9), 1'b1);
            drv_end(1'b1);
         end else begin
            drv_frame(cmd, frm, 10, 1'b1);
            if (rd_data_path) begin
               nm = ($urandom_range(0, 1) == 1) ? 8 : $urandom_range(1, 7);
               drv_read(8'($urandom), $urandom_range(0, 3), nm);
               drv_end(nm < 8);
            end else begin
               drv_hold($urandom_range(0, 2));
               drv_end(1'b0);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      // get into a read reply that drives ones
      if (!exp_flag) begin
         drv_frame(1'b1, 10'h207, 10, 1'b0);
         drv_end(1'b0);
      end
      drv_frame(1'b1, 10'h300, 10, 1'b0);
      tx_valid = 1'b1; tx_data = 8'hFF;
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (MISO !== 1'b1) begin n_err++; $display("FAIL pre_rst_miso: got %0b want 1", MISO); end
      #2 rst_n = 1'b0;
      #1;
      exp_rx_data = 10'h000; exp_flag = 1'b0;
      n_vec++; if (MISO !== 1'b0) begin n_err++; $display("FAIL rst_mid_miso: got %0b want 0", MISO); end
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_rx_valid: got %0b want 0", rx_valid); end
      n_vec++; if (dut.rd_addr_flag_q !== 1'b0) begin n_err++; $display("FAIL rst_mid_flag: got %0b want 0", dut.rd_addr_flag_q); end
      n_vec++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL rst_mid_rx_data: got %0h want 0", rx_data); end
      SS_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // reset while rx_valid is high, then a partial frame cut by reset
      drv_frame(1'b0, 10'h1E7, 10, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      exp_rx_data = 10'h000;
      n_vec++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rxv_rx_valid: got %0b want 0", rx_valid); end
      n_vec++; if (rx_data !== 10'h000) begin n_err++; $display("FAIL rst_rxv_rx_data: got %0h want 0", rx_data); end
      SS_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drv_frame(1'b0, 10'h0FF, 6, 1'b0);
      rst_n = 1'b0; SS_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drv_frame(1'b0, 10'h0C3, 10, 1'b0);
      drv_end(1'b0);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_spi_slave

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, RAM data/address width; rx frame width is DATA_WIDTH+2.
REQ-002 SHALL have port: clk  input  1  system clock; SPI bit rate equals clk rate, all sampling on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: SS_n  input  1  slave select, active-low, frames a transaction.
REQ-005 SHALL have port: MOSI  input  1  serial data in, MSB first.
REQ-006 SHALL have port: MISO  output  1  serial data out, MSB first.
REQ-007 SHALL have port: rx_data  output  DATA_WIDTH+2  parallel frame to RAM; [9:8] command, [7:0] address/data.
REQ-008 SHALL have port: rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-009 SHALL have port: tx_data  input  DATA_WIDTH  read data from RAM.
REQ-010 SHALL have port: tx_valid  input  1  tx_data valid; sampled only in READ_DATA after rx_valid.

Function
REQ-011 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD SHALL occur on the first rising edge with SS_n low; otherwise remain in IDLE.
REQ-013 CHK_CMD SHALL sample MOSI as command bit (not stored): 0 -> WRITE; 1 with rd_addr_flag=0 -> READ_ADD; 1 with rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA SHALL shift MOSI into a 10-bit register MSB first using a 4-bit bit counter, 10 cycles per frame.
REQ-015 The cycle after the 10th bit is sampled, rx_data SHALL present the frame and rx_valid SHALL be high for exactly one cycle; rx_data SHALL hold until next frame completes.
REQ-016 READ_ADD completion SHALL set rd_addr_flag to 1.
REQ-017 After rx_valid in READ_DATA, the block SHALL wait for tx_valid; on the first cycle tx_valid is high it SHALL latch tx_data.
REQ-018 Starting the cycle after latching, MISO SHALL drive the latched byte bit 7 down to bit 0, one bit per cycle, 8 cycles; rd_addr_flag SHALL clear after bit 0.
REQ-019 MISO SHALL be 0 whenever not serialising.
REQ-020 After frame completion (and serialisation in READ_DATA), the FSM SHALL stay in its state, ignoring MOSI, until SS_n high.
REQ-021 SS_n high in any non-IDLE state SHALL return to IDLE the next cycle; the bit counter clears, no rx_valid is generated for a partial frame, MISO returns to 0.
REQ-022 Abort in READ_DATA before bit 0 is driven SHALL leave rd_addr_flag set; abort in READ_ADD before completion SHALL leave rd_addr_flag unchanged.
REQ-023 tx_valid outside the REQ-017 window SHALL be ignored.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, MISO 0, rx_valid 0, rx_data 0, rd_addr_flag 0, bit counter 0, tx latch 0.
REQ-025 Reset mid-transaction SHALL discard the partial frame; first post-reset transaction starts only on a new SS_n low in IDLE.

Configuration
REQ-026 Macro SPI_SLAVE_FRAME_ERR_EN defined: SHALL add output frame_err (1 bit), high for one cycle when REQ-021 aborts a frame with bit counter nonzero or serialisation incomplete; reset 0.
REQ-027 Macro undefined: frame_err port and logic SHALL be absent; aborts are silent; all other behaviour identical.

Structure
REQ-028 Package spi_pkg SHALL hold the FSM state encoding, command codes (00 wr addr, 01 wr data, 10 rd addr, 11 rd data) and frame width constant.
REQ-029 Sub-module spi_tx_serializer SHALL implement tx latch, 3-bit counter and MISO shift (REQ-017..019); FSM, rx shifter, flag stay in spi_slave.

Verification
REQ-030 Write addr: SS_n low, MOSI 0 then 00_1010_0101 -> rx_valid pulse 12 cycles after SS_n low, rx_data=0x0A5.
REQ-031 Write data: cmd 0, frame 01_0011_1100 -> rx_data=0x13C, rd_addr_flag stays 0.
REQ-032 Read: cmd 1, frame 10_0000_0111 -> rx_data=0x207, flag=1; new frame cmd 1, 11_0000_0000 -> rx_data=0x300; tx_valid=1, tx_data=0xC3 two cycles later -> MISO 1,1,0,0,0,0,1,1 starting next cycle; flag=0.
REQ-033 Abort: SS_n high after 5 frame bits -> no rx_valid, IDLE next cycle, frame_err pulse when macro defined.
REQ-034 Async reset asserted during MISO serialisation -> MISO=0, rx_valid=0 immediately, flag=0.
REQ-035 Read with flag=1 interrupted after 4 MISO bits -> flag stays 1; next cmd 1 goes to READ_DATA.
